// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate unit: one single-bit step per clock, done pulses amount+1 cycles after start.
// start is only sampled while idle; requests during SHIFT or DONE are dropped, not queued.
module shift_seq #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] in_i,
   input  logic             cin_i,
   input  logic [2:0]       mode_i,
   input  logic [AW-1:0]    amount_i,
   output logic [WIDTH-1:0] out_o,
   output logic             cout_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam logic [2:0] M_LSL  = 3'd0;
   localparam logic [2:0] M_LSR  = 3'd1;
   localparam logic [2:0] M_ASR  = 3'd2;
   localparam logic [2:0] M_ROL  = 3'd3;
   localparam logic [2:0] M_ROR  = 3'd4;
   localparam logic [2:0] M_RCL  = 3'd5;
   localparam logic [2:0] M_RCR  = 3'd6;
   localparam logic [2:0] M_LSLF = 3'd7;

   localparam logic [AW-1:0] CNT_ZERO = '0;
   localparam logic [AW-1:0] CNT_ONE  = AW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] data_q, data_d;
   logic             carry_q, carry_d;
   logic             fill_q;
   logic [AW-1:0]    cnt_q;
   logic [2:0]       mode_q;
   logic             busy_q;
   logic             done_q;

   // Single-bit step; RCL/RCR treat {carry,data} as one WIDTH+1-bit ring.
   always_comb begin
      data_d  = data_q;
      carry_d = carry_q;
      case (mode_q)
         M_LSL: begin
            carry_d = data_q[WIDTH-1];
            data_d  = {data_q[WIDTH-2:0], 1'b0};
         end
         M_LSR: begin
            carry_d = data_q[0];
            data_d  = {1'b0, data_q[WIDTH-1:1]};
         end
         M_ASR: begin
            carry_d = data_q[0];
            data_d  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
         end
         M_ROL: begin
            carry_d = data_q[WIDTH-1];
            data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
         end
         M_ROR: begin
            carry_d = data_q[0];
            data_d  = {data_q[0], data_q[WIDTH-1:1]};
         end
         M_RCL: begin
            carry_d = data_q[WIDTH-1];
            data_d  = {data_q[WIDTH-2:0], carry_q};
         end
         M_RCR: begin
            carry_d = data_q[0];
            data_d  = {carry_q, data_q[WIDTH-1:1]};
         end
         M_LSLF: begin
            carry_d = data_q[WIDTH-1];
            data_d  = {data_q[WIDTH-2:0], fill_q};
         end
         default: begin
            data_d  = data_q;
            carry_d = carry_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         carry_q <= 1'b0;
         fill_q  <= 1'b0;
         cnt_q   <= '0;
         mode_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  data_q  <= in_i;
                  carry_q <= cin_i;
                  fill_q  <= cin_i;
                  cnt_q   <= amount_i;
                  mode_q  <= mode_i;
                  busy_q  <= 1'b1;
                  if (amount_i == CNT_ZERO) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               data_q  <= data_d;
               carry_q <= carry_d;
               cnt_q   <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out_o  = data_q;
   assign cout_o = carry_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: doc/shift_seq.md
# shift_seq

Parametrised sequential shift/rotate unit that follows the 8-bit combinational shifter. It accepts an operand, carry-in, mode and shift amount, then performs one single-bit step per clock until the amount is exhausted, and reports the result and carry-out with a start/busy/done handshake. It sits beside the ALU datapath as a multi-cycle functional unit, with area traded for latency.

## Interface
- WIDTH, 8: operand width in bits, ≥2
- AW, 4: shift-amount width; amounts 0..2^AW−1 are legal
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- start  in  1  request; sampled only when busy=0
- in  in  WIDTH  operand
- cin  in  1  carry/fill input
- mode  in  3  operation select
- amount  in  AW  number of single-bit steps
- out  out  WIDTH  result register
- cout  out  1  carry register (last bit shifted out)
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SHIFT, DONE. busy = (state != IDLE).
- On a start accepted in IDLE:
  - load in→data reg, cin→carry reg, cin→fill reg, amount→cnt, mode→mode reg.
  - next state is DONE if amount=0, else SHIFT.
- Each SHIFT cycle performs one step on data/carry and decrements cnt. The cycle where cnt goes 1→0 moves to DONE.
- DONE lasts exactly one cycle (done=1), then returns to IDLE.
- Step per mode, with data d[WIDTH-1:0] and carry c:
  - 0 LSL: c←d[W-1], d←{d[W-2:0],0}
  - 1 LSR: c←d[0], d←{0,d[W-1:1]}
  - 2 ASR: c←d[0], d←{d[W-1],d[W-1:1]}
  - 3 ROL: c←d[W-1], d←{d[W-2:0],d[W-1]}
  - 4 ROR: c←d[0], d←{d[0],d[W-1:1]}
  - 5 RCL (WIDTH+1-bit rotate): c←d[W-1], d←{d[W-2:0],c}
  - 6 RCR: c←d[0], d←{c,d[W-1:1]}
  - 7 LSL-fill: c←d[W-1], d←{d[W-2:0],fill}; fill is the cin value latched at start and stays constant.
- amount=0: out=in, cout=cin for every mode.
- out/cout directly reflect the data/carry registers. They change during SHIFT and are stable from the DONE cycle until the next accepted start.
- start while busy=1 is ignored. in, cin, mode and amount are don't-care after acceptance.
- start asserted in the DONE cycle is ignored. A start is accepted earliest in the following IDLE cycle.

## Timing
- Reset (async assert, sync-released use): state=IDLE, out=0, cout=0, busy=0, done=0, cnt=0.
- Reset mid-operation aborts immediately; no done pulse follows.
- Call the accepting edge E0.
  - busy=1 from after E0.
  - done=1 during the cycle after edge E(amount), where E(n) is the n-th edge after E0.
  - The start-to-done latency is amount+1 cycles.
  - busy falls after edge E(amount+1).
- Back-to-back throughput: one operation per amount+2 cycles.
- Holding start high continuously re-triggers on each IDLE cycle.

## Test plan
- WIDTH=8, in=8'hAA, mode=0, amount=1, cin=0 -> done 2 cycles after E0 (1 SHIFT + DONE), out=8'h54, cout=1.
- in=8'hAA, mode=4 (ROR), amount=3 -> out=8'h55, cout=0; busy high exactly 4 cycles.
- in=8'hAA, mode=2 (ASR), amount=2 -> out=8'hEA, cout=1.
- in=8'hAA, mode=5 (RCL), cin=1, amount=9 -> out=8'hAA, cout=1 (full 9-bit rotation is identity).
- in=8'hAA, mode=7, cin=1, amount=3 -> out=8'h57, cout=1. Then amount=0, any mode, cin=0 -> out=8'hAA, cout=0, done during the first cycle after E0.
- Start mode=1, amount=15. Pulse start with different operands during SHIFT -> second request ignored, result of first only. Repeat, asserting rst_n=0 mid-SHIFT -> out=0, cout=0, busy=0, no done. A following start completes normally.
